// File: rtl/bin_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    localparam int BCD_DIGIT_W = 4;

    // ceil(bin_w * log10(2)) using a fixed-point log10(2); exact for practical widths
    function automatic int bcd_digits_needed(int bin_w);
        return (bin_w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bin_bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_add3_cell
    import bin_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_in,
    output logic [BCD_DIGIT_W-1:0] d_out
);

    assign d_out = (d_in >= BCD_DIGIT_W'(5)) ? d_in + BCD_DIGIT_W'(3) : d_in;

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional macro BI_BCD_SIGNED_EN: two's-complement input and an out_neg sign output.
module bin_bcd_seq
    import bin_bcd_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BIN_W-1:0]            in_bin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                        out_ovf
`ifdef BI_BCD_SIGNED_EN
    ,
    output logic                        out_neg
`endif
);

    localparam int BCD_W       = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W       = $clog2(BIN_W + 1);
    localparam int DIGITS_FULL = bcd_digits_needed(BIN_W);

    if (DIGITS < 1 || DIGITS_FULL < 1 || BIN_W < 4) begin : g_bad_param
        $error("bin_bcd_seq: needs BIN_W >= 4 and DIGITS >= 1");
    end

    bcd_state_t         state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic               out_ovf_q, out_ovf_d;
`ifdef BI_BCD_SIGNED_EN
    logic               neg_q, neg_d;
    logic               out_neg_q, out_neg_d;
`endif

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [BIN_W-1:0]   bin_load;

    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3_cell u_add3 (
            .d_in  (bcd_q[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .d_out (bcd_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};

`ifdef BI_BCD_SIGNED_EN
    // -2^(BIN_W-1) negates to itself, which is the correct unsigned magnitude
    assign bin_load = in_bin[BIN_W-1] ? -in_bin : in_bin;
`else
    assign bin_load = in_bin;
`endif

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_bcd_d   = out_bcd_q;
        out_ovf_d   = out_ovf_q;
`ifdef BI_BCD_SIGNED_EN
        neg_d       = neg_q;
        out_neg_d   = out_neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d      = bin_load;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    out_ovf_d  = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
`ifdef BI_BCD_SIGNED_EN
                    neg_d      = in_bin[BIN_W-1];
`endif
                end
            end
            SHIFT: begin
                bcd_d = bcd_shift;
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                ovf_d = ovf_q | bcd_adj[BCD_W-1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_bcd_d   = bcd_shift;
                    out_ovf_d   = ovf_q | bcd_adj[BCD_W-1];
`ifdef BI_BCD_SIGNED_EN
                    out_neg_d   = neg_q;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    out_bcd_d   = '0;
`ifdef BI_BCD_SIGNED_EN
                    out_neg_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                out_bcd_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_ovf_q   <= 1'b0;
`ifdef BI_BCD_SIGNED_EN
            neg_q       <= 1'b0;
            out_neg_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            out_ovf_q   <= out_ovf_d;
`ifdef BI_BCD_SIGNED_EN
            neg_q       <= neg_d;
            out_neg_q   <= out_neg_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign out_ovf   = out_ovf_q;
`ifdef BI_BCD_SIGNED_EN
    assign out_neg   = out_neg_q;
`endif

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Randomised bench for bin_bcd_seq: a 10-digit and a 4-digit instance against a decimal model.
module tb_bin_bcd_seq;

    localparam int BUDGET = 100;

    logic        clk;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_bin    [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        out_ovf   [2];
    logic [39:0] bcd_a;
    logic [15:0] bcd_b;
`ifdef BI_BCD_SIGNED_EN
    logic        out_neg   [2];
`endif

    int checks = 0;
    int errors = 0;

    bin_bcd_seq #(.BIN_W(32), .DIGITS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_bin    (in_bin[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_bcd   (bcd_a),
        .out_ovf   (out_ovf[0])
`ifdef BI_BCD_SIGNED_EN
        ,
        .out_neg   (out_neg[0])
`endif
    );

    bin_bcd_seq #(.BIN_W(32), .DIGITS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_bin    (in_bin[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_bcd   (bcd_b),
        .out_ovf   (out_ovf[1])
`ifdef BI_BCD_SIGNED_EN
        ,
        .out_neg   (out_neg[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] obs_bcd(input int sel);
        return (sel == 0) ? bcd_a : {24'h0, bcd_b};
    endfunction

    function automatic logic [63:0] ref_mag(input logic [31:0] v);
        logic [63:0] x;
        x = {32'h0, v};
`ifdef BI_BCD_SIGNED_EN
        if (v[31]) x = 64'h1_0000_0000 - x;
`endif
        return x;
    endfunction

    // Decimal digits by repeated division; overflow when magnitude >= 10^digits
    task automatic ref_bcd(input logic [31:0] v, input int digits,
                           output logic [39:0] b, output logic o);
        logic [63:0] mag, m, p;
        mag = ref_mag(v);
        m   = mag;
        p   = 64'd1;
        b   = '0;
        for (int k = 0; k < digits; k++) begin
            b[4*k +: 4] = 4'(m % 64'd10);
            m = m / 64'd10;
            p = p * 64'd10;
        end
        o = (mag >= p);
    endtask

    task automatic start_conv(input int sel, input logic [31:0] v);
        logic [39:0] eb;
        logic        eo;
        int          n;
        ref_bcd(v, (sel == 0) ? 10 : 4, eb, eo);
        in_valid[sel] = 1'b1;
        in_bin[sel]   = v;
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
        check("busy_ready", {63'h0, in_ready[sel]}, 64'h0);
        n = 0;
        while (!out_valid[sel] && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'd32);
        check("bcd", {24'h0, obs_bcd(sel)}, {24'h0, eb});
        check("ovf", {63'h0, out_ovf[sel]}, {63'h0, eo});
        check("done_ready", {63'h0, in_ready[sel]}, 64'h0);
`ifdef BI_BCD_SIGNED_EN
        check("neg", {63'h0, out_neg[sel]}, {63'h0, v[31]});
`endif
    endtask

    task automatic finish_conv(input int sel);
        out_ready[sel] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[sel] = 1'b0;
        check("idle_valid", {63'h0, out_valid[sel]}, 64'h0);
        check("idle_ready", {63'h0, in_ready[sel]}, 64'h1);
        check("idle_bcd", {24'h0, obs_bcd(sel)}, 64'h0);
    endtask

    initial begin
        logic [39:0] eb;
        logic        eo;
        logic [31:0] v;
        int          m;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_bin[i]    = '0;
            out_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {63'h0, in_ready[0]}, 64'h1);
        check("rst_valid", {63'h0, out_valid[0]}, 64'h0);
        check("rst_bcd", {24'h0, bcd_a}, 64'h0);
        check("rst_ovf", {63'h0, out_ovf[0]}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        start_conv(0, 32'd0);          finish_conv(0);
        start_conv(0, 32'd1234);       finish_conv(0);
        start_conv(0, 32'hFFFF_FFFF);  finish_conv(0);
        start_conv(1, 32'd12345);      finish_conv(1);
        start_conv(1, 32'd9999);       finish_conv(1);
        start_conv(1, 32'd10000);      finish_conv(1);

        // Consumer stalls in DONE while the source keeps poking in_valid
        start_conv(0, 32'd987654321);
        ref_bcd(32'd987654321, 10, eb, eo);
        for (int i = 0; i < 20; i++) begin
            in_valid[0] = 1'($urandom % 2);
            in_bin[0]   = $urandom;
            @(posedge clk);
            #1;
            check("hold_bcd", {24'h0, bcd_a}, {24'h0, eb});
            check("hold_ready", {63'h0, in_ready[0]}, 64'h0);
            check("hold_valid", {63'h0, out_valid[0]}, 64'h1);
        end
        in_valid[0] = 1'b0;
        finish_conv(0);
        start_conv(0, 32'd55);         finish_conv(0);

        // Reset in the middle of a conversion
        in_valid[0] = 1'b1;
        in_bin[0]   = 32'h00AB_CDEF;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_ready", {63'h0, in_ready[0]}, 64'h1);
        check("midrst_valid", {63'h0, out_valid[0]}, 64'h0);
        check("midrst_bcd", {24'h0, bcd_a}, 64'h0);
        check("midrst_ovf", {63'h0, out_ovf[0]}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_conv(0, 32'd7);          finish_conv(0);

        // Back-to-back throughput with out_ready tied high
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_bin[0]    = 32'd42;
        m = 0;
        while (!out_valid[0] && m < BUDGET) begin
            @(posedge clk);
            #1;
            m++;
        end
        m = 0;
        do begin
            @(posedge clk);
            #1;
            m++;
        end while (m < BUDGET && !(m > 1 && out_valid[0]));
        check("throughput", 64'(m), 64'd34);
        check("tput_bcd", {24'h0, bcd_a}, 64'h42);
        in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        check("tput_idle", {63'h0, in_ready[0]}, 64'h1);

`ifdef BI_BCD_SIGNED_EN
        start_conv(0, 32'hFFFF_FFFF);  finish_conv(0);
        start_conv(0, 32'h8000_0000);  finish_conv(0);
        start_conv(1, 32'hFFFF_CFC7);  finish_conv(1);
`endif

        for (int i = 0; i < 12; i++) begin
            v = $urandom;
            start_conv(0, v);
            finish_conv(0);
            v = (i % 2 == 0) ? $urandom_range(0, 30000) : $urandom;
            start_conv(1, v);
            finish_conv(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
